mtx_result_collector: RTL and testbench



---
 rtl/mtx_result_collector.sv | 165 ++++++++++++++++
 tb/tb_mtx_result_collector.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtx_result_collector.sv
// ---------------------------------------------------------------------------
// mtx_result_collector
//
// Downstream stage of the dot-product unit in the 8x8 matrix-multiply
// accelerator. Collects tagged (destination index, dot product) results into
// a 64-entry store, tracks which C elements have arrived, flags completion,
// reports job latency in ACLK cycles and offers a registered read port for
// the AXI-Lite read path.
//
// Ports:
//   ACLK        clock
//   ARESETN     asynchronous active-low reset
//   C_START     single-cycle pulse: clear and arm a new job
//   WR_VALID    result valid from the dot-product stage
//   WR_DEST     destination index of the result (row*8+col)
//   WR_DATA     dot-product result
//   RD_EN       read request
//   RD_ADDR     read index
//   RD_DATA     registered read data (holds when RD_VALID is low)
//   RD_VALID    one-cycle pulse, RD_DATA valid
//   CYCLE_IN    free-running cycle counter value
//   LATENCY     cycles from arm to last result of the job
//   FILL_COUNT  number of distinct entries written this job
//   STATUS      00 IDLE, 01 COLLECT, 10 DONE
//   DONE        high while in DONE
//   DUP_ERR     sticky duplicate-destination flag for the current job
// ---------------------------------------------------------------------------
module mtx_result_collector #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 6,
  parameter int CNT_WIDTH  = 64
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  C_START,
  input  logic                  WR_VALID,
  input  logic [IDX_WIDTH-1:0]  WR_DEST,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  RD_EN,
  input  logic [IDX_WIDTH-1:0]  RD_ADDR,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RD_VALID,
  input  logic [CNT_WIDTH-1:0]  CYCLE_IN,
  output logic [CNT_WIDTH-1:0]  LATENCY,
  output logic [IDX_WIDTH:0]    FILL_COUNT,
  output logic [1:0]            STATUS,
  output logic                  DONE,
  output logic                  DUP_ERR
);

  localparam int ENTRIES = 1 << IDX_WIDTH;
  localparam logic [IDX_WIDTH:0] LAST_FILL = (IDX_WIDTH + 1)'(ENTRIES - 1);

  // Encodings double as the STATUS field.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COLLECT = 2'b01,
    ST_DONE    = 2'b10
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [DATA_WIDTH-1:0]   store [ENTRIES];
  logic [ENTRIES-1:0]      written;
  logic [IDX_WIDTH:0]      fill_count;
  logic                    dup_err;
  logic [CNT_WIDTH-1:0]    latency;
  logic [CNT_WIDTH-1:0]    start_snap;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_valid;

  logic accept;
  logic new_entry;
  logic dup_hit;
  logic completes;

  // Write qualification and next-state logic. An arm in the same cycle wins
  // over a write, so the write is dropped rather than landing in the new job.
  always_comb begin
    accept    = 1'b0;
    new_entry = 1'b0;
    dup_hit   = 1'b0;
    completes = 1'b0;
    state_d   = state_q;

    accept    = (state_q == ST_COLLECT) && WR_VALID && !C_START;
    new_entry = accept && !written[WR_DEST];
    dup_hit   = accept && written[WR_DEST];
    completes = new_entry && (fill_count == LAST_FILL);

    if (C_START) begin
      state_d = ST_COLLECT;
    end else if (completes) begin
      state_d = ST_DONE;
    end
  end

  // State register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Job bookkeeping: arrival bitmap, fill count, duplicate flag and latency.
  // Unsigned subtraction makes a wrapped cycle counter give the right answer.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      written    <= '0;
      fill_count <= '0;
      dup_err    <= 1'b0;
      latency    <= '0;
      start_snap <= '0;
    end else if (C_START) begin
      written    <= '0;
      fill_count <= '0;
      dup_err    <= 1'b0;
      latency    <= '0;
      start_snap <= CYCLE_IN;
    end else begin
      if (new_entry) begin
        written[WR_DEST] <= 1'b1;
        fill_count       <= fill_count + 1'b1;
      end
      if (dup_hit) begin
        dup_err <= 1'b1;
      end
      if (completes) begin
        latency <= CYCLE_IN - start_snap;
      end
    end
  end

  // Result storage has no reset; the bitmap masks stale contents on read.
  always_ff @(posedge ACLK) begin
    if (new_entry) begin
      store[WR_DEST] <= WR_DATA;
    end
  end

  // Registered read port. Reads see the bitmap and store as they were before
  // this edge, so a same-cycle write or arm does not affect the returned data.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= RD_EN;
      if (RD_EN) begin
        rd_data <= written[RD_ADDR] ? store[RD_ADDR] : '0;
      end
    end
  end

  assign RD_DATA    = rd_data;
  assign RD_VALID   = rd_valid;
  assign LATENCY    = latency;
  assign FILL_COUNT = fill_count;
  assign STATUS     = state_q;
  assign DONE       = (state_q == ST_DONE);
  assign DUP_ERR    = dup_err;

endmodule

// File: tb/tb_mtx_result_collector.sv
// ---------------------------------------------------------------------------
// tb_mtx_result_collector
//
// Directed testbench for mtx_result_collector. Each test task drives its
// scenario and compares DUT outputs against hand-computed values inline.
// Inputs change 1 time unit after the rising edge, outputs are observed at
// the same point, so every observation reflects the edge just taken.
// ---------------------------------------------------------------------------
module tb_mtx_result_collector;

  logic        ACLK;
  logic        ARESETN;
  logic        C_START;
  logic        WR_VALID;
  logic [5:0]  WR_DEST;
  logic [31:0] WR_DATA;
  logic        RD_EN;
  logic [5:0]  RD_ADDR;
  logic [31:0] RD_DATA;
  logic        RD_VALID;
  logic [63:0] CYCLE_IN;
  logic [63:0] LATENCY;
  logic [6:0]  FILL_COUNT;
  logic [1:0]  STATUS;
  logic        DONE;
  logic        DUP_ERR;

  int checks;
  int passed;

  mtx_result_collector #(
    .DATA_WIDTH(32),
    .IDX_WIDTH (6),
    .CNT_WIDTH (64)
  ) dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .C_START   (C_START),
    .WR_VALID  (WR_VALID),
    .WR_DEST   (WR_DEST),
    .WR_DATA   (WR_DATA),
    .RD_EN     (RD_EN),
    .RD_ADDR   (RD_ADDR),
    .RD_DATA   (RD_DATA),
    .RD_VALID  (RD_VALID),
    .CYCLE_IN  (CYCLE_IN),
    .LATENCY   (LATENCY),
    .FILL_COUNT(FILL_COUNT),
    .STATUS    (STATUS),
    .DONE      (DONE),
    .DUP_ERR   (DUP_ERR)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Advance one clock; the cycle counter models a free-running counter.
  task automatic step();
    @(posedge ACLK);
    #1;
    CYCLE_IN = CYCLE_IN + 64'd1;
  endtask

  // Arm a new job with the counter showing start_cycle on the arm edge.
  task automatic arm(input logic [63:0] start_cycle);
    CYCLE_IN = start_cycle;
    C_START  = 1'b1;
    step();
    C_START  = 1'b0;
  endtask

  // Back-to-back writes dest first..first+count-1 with data = dest*3.
  task automatic write_seq(input int first, input int count);
    for (int k = first; k < first + count; k++) begin
      WR_VALID = 1'b1;
      WR_DEST  = 6'(k);
      WR_DATA  = 32'(k * 3);
      step();
    end
    WR_VALID = 1'b0;
  endtask

  task automatic single_write(input logic [5:0] dest, input logic [31:0] data);
    WR_VALID = 1'b1;
    WR_DEST  = dest;
    WR_DATA  = data;
    step();
    WR_VALID = 1'b0;
  endtask

  task automatic single_read(input logic [5:0] addr);
    RD_EN   = 1'b1;
    RD_ADDR = addr;
    step();
    RD_EN   = 1'b0;
  endtask

  task automatic test_reset();
    ARESETN  = 1'b0;
    C_START  = 1'b0;
    WR_VALID = 1'b0;
    WR_DEST  = '0;
    WR_DATA  = '0;
    RD_EN    = 1'b0;
    RD_ADDR  = '0;
    CYCLE_IN = '0;
    step();
    step();
    ARESETN = 1'b1;
    step();
    checks++; if (STATUS !== 2'b00) $display("[TB] FAIL reset_status: got %0h want 0", STATUS); else passed++;
    checks++; if (DONE !== 1'b0) $display("[TB] FAIL reset_done: got %0h want 0", DONE); else passed++;
    checks++; if (DUP_ERR !== 1'b0) $display("[TB] FAIL reset_dup: got %0h want 0", DUP_ERR); else passed++;
    checks++; if (FILL_COUNT !== 7'd0) $display("[TB] FAIL reset_fill: got %0d want 0", FILL_COUNT); else passed++;
    checks++; if (LATENCY !== 64'd0) $display("[TB] FAIL reset_latency: got %0d want 0", LATENCY); else passed++;
    checks++; if (RD_DATA !== 32'd0) $display("[TB] FAIL reset_rd_data: got %0h want 0", RD_DATA); else passed++;
    checks++; if (RD_VALID !== 1'b0) $display("[TB] FAIL reset_rd_valid: got %0h want 0", RD_VALID); else passed++;
  endtask

  task automatic test_full_job();
    arm(64'd100);
    checks++; if (STATUS !== 2'b01) $display("[TB] FAIL full_armed_status: got %0h want 1", STATUS); else passed++;
    write_seq(0, 63);
    checks++; if (FILL_COUNT !== 7'd63) $display("[TB] FAIL full_fill63: got %0d want 63", FILL_COUNT); else passed++;
    checks++; if (DONE !== 1'b0) $display("[TB] FAIL full_done_early: got %0h want 0", DONE); else passed++;
    // Last write lands with the counter at 164.
    write_seq(63, 1);
    checks++; if (DONE !== 1'b1) $display("[TB] FAIL full_done: got %0h want 1", DONE); else passed++;
    checks++; if (STATUS !== 2'b10) $display("[TB] FAIL full_status: got %0h want 2", STATUS); else passed++;
    checks++; if (FILL_COUNT !== 7'd64) $display("[TB] FAIL full_fill64: got %0d want 64", FILL_COUNT); else passed++;
    checks++; if (LATENCY !== 64'd64) $display("[TB] FAIL full_latency: got %0d want 64", LATENCY); else passed++;
    checks++; if (DUP_ERR !== 1'b0) $display("[TB] FAIL full_dup: got %0h want 0", DUP_ERR); else passed++;
    single_read(6'd10);
    checks++; if (RD_VALID !== 1'b1) $display("[TB] FAIL full_rd_valid: got %0h want 1", RD_VALID); else passed++;
    checks++; if (RD_DATA !== 32'd30) $display("[TB] FAIL full_rd_data10: got %0d want 30", RD_DATA); else passed++;
    step();
    checks++; if (RD_VALID !== 1'b0) $display("[TB] FAIL full_rd_valid_drop: got %0h want 0", RD_VALID); else passed++;
    checks++; if (RD_DATA !== 32'd30) $display("[TB] FAIL full_rd_hold: got %0d want 30", RD_DATA); else passed++;
    // A write while DONE must leave the job untouched.
    single_write(6'd3, 32'd999);
    checks++; if (DUP_ERR !== 1'b0) $display("[TB] FAIL done_write_dup: got %0h want 0", DUP_ERR); else passed++;
    checks++; if (FILL_COUNT !== 7'd64) $display("[TB] FAIL done_write_fill: got %0d want 64", FILL_COUNT); else passed++;
    single_read(6'd3);
    checks++; if (RD_DATA !== 32'd9) $display("[TB] FAIL done_write_data: got %0d want 9", RD_DATA); else passed++;
  endtask

  task automatic test_duplicate();
    arm(64'd300);
    single_write(6'd5, 32'hAAAA);
    single_write(6'd5, 32'h5555);
    checks++; if (DUP_ERR !== 1'b1) $display("[TB] FAIL dup_flag: got %0h want 1", DUP_ERR); else passed++;
    checks++; if (FILL_COUNT !== 7'd1) $display("[TB] FAIL dup_fill: got %0d want 1", FILL_COUNT); else passed++;
    single_read(6'd5);
    checks++; if (RD_DATA !== 32'hAAAA) $display("[TB] FAIL dup_keep_first: got %0h want aaaa", RD_DATA); else passed++;
    // Arm and read together: the read sees the job being cleared.
    RD_EN   = 1'b1;
    RD_ADDR = 6'd5;
    arm(64'd400);
    RD_EN   = 1'b0;
    checks++; if (RD_DATA !== 32'hAAAA) $display("[TB] FAIL arm_read_preclear: got %0h want aaaa", RD_DATA); else passed++;
    checks++; if (DUP_ERR !== 1'b0) $display("[TB] FAIL rearm_dup: got %0h want 0", DUP_ERR); else passed++;
    checks++; if (FILL_COUNT !== 7'd0) $display("[TB] FAIL rearm_fill: got %0d want 0", FILL_COUNT); else passed++;
    single_read(6'd5);
    checks++; if (RD_DATA !== 32'd0) $display("[TB] FAIL rearm_read5: got %0h want 0", RD_DATA); else passed++;
  endtask

  task automatic test_idle_drop();
    ARESETN = 1'b0;
    step();
    ARESETN = 1'b1;
    step();
    single_write(6'd7, 32'h1234);
    checks++; if (FILL_COUNT !== 7'd0) $display("[TB] FAIL idle_fill: got %0d want 0", FILL_COUNT); else passed++;
    checks++; if (DUP_ERR !== 1'b0) $display("[TB] FAIL idle_dup: got %0h want 0", DUP_ERR); else passed++;
    checks++; if (STATUS !== 2'b00) $display("[TB] FAIL idle_status: got %0h want 0", STATUS); else passed++;
    // Write coincident with the arm is dropped.
    WR_VALID = 1'b1;
    WR_DEST  = 6'd7;
    WR_DATA  = 32'h1234;
    arm(64'd500);
    WR_VALID = 1'b0;
    checks++; if (STATUS !== 2'b01) $display("[TB] FAIL arm_wr_status: got %0h want 1", STATUS); else passed++;
    checks++; if (FILL_COUNT !== 7'd0) $display("[TB] FAIL arm_wr_fill: got %0d want 0", FILL_COUNT); else passed++;
    single_read(6'd7);
    checks++; if (RD_DATA !== 32'd0) $display("[TB] FAIL arm_wr_read7: got %0h want 0", RD_DATA); else passed++;
  endtask

  task automatic test_wrap();
    // Armed at 2^64-10; last of 64 back-to-back writes lands at 54.
    arm(64'hFFFF_FFFF_FFFF_FFF6);
    write_seq(0, 64);
    checks++; if (CYCLE_IN !== 64'd55) $display("[TB] FAIL wrap_counter_setup: got %0d want 55", CYCLE_IN); else passed++;
    checks++; if (DONE !== 1'b1) $display("[TB] FAIL wrap_done: got %0h want 1", DONE); else passed++;
    checks++; if (LATENCY !== 64'd64) $display("[TB] FAIL wrap_latency: got %0d want 64", LATENCY); else passed++;
  endtask

  task automatic test_same_cycle_rw();
    arm(64'd700);
    WR_VALID = 1'b1;
    WR_DEST  = 6'd20;
    WR_DATA  = 32'hBEEF;
    RD_EN    = 1'b1;
    RD_ADDR  = 6'd20;
    step();
    WR_VALID = 1'b0;
    RD_EN    = 1'b0;
    checks++; if (RD_VALID !== 1'b1) $display("[TB] FAIL rw_valid: got %0h want 1", RD_VALID); else passed++;
    checks++; if (RD_DATA !== 32'd0) $display("[TB] FAIL rw_prewrite: got %0h want 0", RD_DATA); else passed++;
    checks++; if (FILL_COUNT !== 7'd1) $display("[TB] FAIL rw_fill: got %0d want 1", FILL_COUNT); else passed++;
    single_read(6'd20);
    checks++; if (RD_DATA !== 32'hBEEF) $display("[TB] FAIL rw_postwrite: got %0h want beef", RD_DATA); else passed++;
  endtask

  task automatic test_reset_mid_job();
    arm(64'd1000);
    write_seq(0, 29);
    // Duplicate of dest 0 with a read of dest 2 in the same cycle.
    WR_VALID = 1'b1;
    WR_DEST  = 6'd0;
    WR_DATA  = 32'h77;
    RD_EN    = 1'b1;
    RD_ADDR  = 6'd2;
    step();
    WR_VALID = 1'b0;
    RD_EN    = 1'b0;
    checks++; if (DUP_ERR !== 1'b1) $display("[TB] FAIL mid_dup_before: got %0h want 1", DUP_ERR); else passed++;
    checks++; if (FILL_COUNT !== 7'd29) $display("[TB] FAIL mid_fill_before: got %0d want 29", FILL_COUNT); else passed++;
    checks++; if (RD_DATA !== 32'd6) $display("[TB] FAIL mid_rd_before: got %0d want 6", RD_DATA); else passed++;
    // Asynchronous reset between edges takes effect at once.
    ARESETN = 1'b0;
    #1;
    checks++; if (STATUS !== 2'b00) $display("[TB] FAIL mid_rst_status: got %0h want 0", STATUS); else passed++;
    checks++; if (FILL_COUNT !== 7'd0) $display("[TB] FAIL mid_rst_fill: got %0d want 0", FILL_COUNT); else passed++;
    checks++; if (DUP_ERR !== 1'b0) $display("[TB] FAIL mid_rst_dup: got %0h want 0", DUP_ERR); else passed++;
    checks++; if (RD_VALID !== 1'b0) $display("[TB] FAIL mid_rst_rd_valid: got %0h want 0", RD_VALID); else passed++;
    checks++; if (RD_DATA !== 32'd0) $display("[TB] FAIL mid_rst_rd_data: got %0h want 0", RD_DATA); else passed++;
    checks++; if (LATENCY !== 64'd0) $display("[TB] FAIL mid_rst_latency: got %0d want 0", LATENCY); else passed++;
    step();
    ARESETN = 1'b1;
    step();
    single_read(6'd2);
    checks++; if (RD_DATA !== 32'd0) $display("[TB] FAIL mid_rst_read2: got %0h want 0", RD_DATA); else passed++;
    arm(64'd5000);
    write_seq(0, 64);
    checks++; if (DONE !== 1'b1) $display("[TB] FAIL mid_rerun_done: got %0h want 1", DONE); else passed++;
    checks++; if (FILL_COUNT !== 7'd64) $display("[TB] FAIL mid_rerun_fill: got %0d want 64", FILL_COUNT); else passed++;
    checks++; if (LATENCY !== 64'd64) $display("[TB] FAIL mid_rerun_latency: got %0d want 64", LATENCY); else passed++;
    single_read(6'd63);
    checks++; if (RD_DATA !== 32'd189) $display("[TB] FAIL mid_rerun_read63: got %0d want 189", RD_DATA); else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_full_job();
    test_duplicate();
    test_idle_drop();
    test_wrap();
    test_same_cycle_rw();
    test_reset_mid_job();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
